arch_step_trace_buffer: RTL and testbench
=========================================

Name: arch_step_trace_buffer

Overview:
Synthesizable, parametrised successor to the single-lane architectural-step probe. It captures up to NCOMMIT retired instructions per cycle (pc, inst) and compacts them in lane order into a DEPTH-entry FIFO. Each entry is tagged with a wrapping retire sequence number so a downstream consumer can detect drops. The buffer is drained through a valid/ready read port by the debug/host bridge, with sticky overflow status.

Parameters:
NCOMMIT, 2, number of retire lanes (1..4)
XLEN, 64, pc width
ILEN, 32, instruction width
DEPTH, 16, FIFO entries; power of two, >= NCOMMIT
SEQ_W, 16, sequence tag width
CNT_W, 32, drop counter width

Ports:
clock  in  1  single clock, rising edge
reset  in  1  asynchronous, active-high reset
enable  in  1  capture enable; 0 ignores all commit lanes
clear  in  1  synchronous flush of FIFO and status
commit_valid  in  NCOMMIT  per-lane retire valid
commit_pc  in  NCOMMIT*XLEN  lane i at bits [i*XLEN +: XLEN]
commit_inst  in  NCOMMIT*ILEN  lane i at bits [i*ILEN +: ILEN]
read_ready  in  1  consumer accepts head entry
read_valid  out  1  FIFO non-empty
read_pc  out  XLEN  head entry pc
read_inst  out  ILEN  head entry inst
read_seq  out  SEQ_W  head entry sequence tag
count  out  log2(DEPTH)+1  current occupancy
overflow  out  1  sticky: at least one group dropped
drop_count  out  CNT_W  total instructions dropped, saturating

Behaviour:
- Reset (async assert): pointers = 0, count = 0, read_valid = 0, overflow = 0, drop_count = 0, seq counter = 0. read_pc/read_inst/read_seq read as 0 while empty. FIFO storage is not reset.
- Group size n = popcount(commit_valid & {NCOMMIT{enable}}). Lanes are compacted in ascending lane index. The lowest valid lane takes the lowest FIFO slot and seq = S, the next takes S+1, and so on.
- Accept rule: free = DEPTH - count, sampled at the start of the cycle. The current-cycle pop does not add space, so there is no combinational path from read_ready to the push decision.
  - If n <= free: all n entries are written and count increases by n.
  - If n > free: the whole group is dropped atomically with no partial write. overflow is set and drop_count increases by n, saturating at all-ones.
- The seq counter advances by n on every cycle with n > 0, whether the group is accepted or dropped. A consumer detects loss as a gap in read_seq. The counter wraps modulo 2^SEQ_W.
- Pop occurs when read_valid && read_ready. The head advances and count decreases by 1.
- Push and pop may occur in the same cycle: count_next = count + (accepted ? n : 0) - pop.
- Latency: an entry written on edge N produces read_valid = 1 and valid head data after edge N. Read outputs are driven combinationally from storage and the head pointer, with no bubble.
- read_pc/read_inst/read_seq are held stable while read_valid && !read_ready.
- Pointers are log2(DEPTH) bits and wrap naturally. Full/empty is determined from count, not from pointer equality.
- clear has priority over push and pop in the same cycle. It returns every register to its reset value, including the seq counter, and commit lanes in that cycle are discarded without being counted.
- Reset asserted mid-burst forces the reset state immediately, independent of the clock.
- enable = 0: no writes, seq does not advance, drops are not counted. Reads continue normally.

Test Plan:
- Single lane: after reset, enable=1, lane0 valid pc=0x8000_0000 inst=0x0000_0013, read_ready=0 -> next cycle read_valid=1, read_pc=0x80000000, read_seq=0, count=1; pulse read_ready -> count=0, read_valid=0.
- Dual-lane compaction: commit_valid=2'b10, lane1 pc=0x100; next cycle 2'b11 with pcs 0x104/0x108 -> pop order 0x100, 0x104, 0x108 with seq 0, 1, 2.
- Overflow: DEPTH=16, fill 15 entries, then issue a 2-lane group, read_ready=0 -> count stays 15, overflow=1, drop_count=2, no partial write; next accepted single entry has seq = 17.
- Full plus simultaneous pop: count=16, read_ready=1, one lane valid -> entry dropped (free sampled as 0), drop_count+1, count=15.
- Seq wrap: SEQ_W=4, push 18 entries while draining -> read_seq sequence 14, 15, 0, 1 around the wrap with no gap.
- Reset mid-operation and clear: with count=5 and overflow=1, assert reset between clock edges -> read_valid, count and overflow drop to 0 immediately. Repeat using clear in a cycle with a concurrent push and pop -> next cycle count=0, drop_count=0, seq restarts at 0.

Source files
------------

// File: rtl/arch_step_trace_buffer.sv
// arch_step_trace_buffer: multi-lane retire trace capture.
// Up to NCOMMIT retired instructions per cycle are compacted in lane order
// into a DEPTH-entry FIFO, each entry tagged with a wrapping retire sequence
// number. A group that does not fit is dropped whole and counted.
module arch_step_trace_buffer #(
  parameter int NCOMMIT = 2,
  parameter int XLEN    = 64,
  parameter int ILEN    = 32,
  parameter int DEPTH   = 16,
  parameter int SEQ_W   = 16,
  parameter int CNT_W   = 32
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      clear,
  input  logic [NCOMMIT-1:0]        commit_valid,
  input  logic [NCOMMIT*XLEN-1:0]   commit_pc,
  input  logic [NCOMMIT*ILEN-1:0]   commit_inst,
  input  logic                      read_ready,
  output logic                      read_valid,
  output logic [XLEN-1:0]           read_pc,
  output logic [ILEN-1:0]           read_inst,
  output logic [SEQ_W-1:0]          read_seq,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      overflow,
  output logic [CNT_W-1:0]          drop_count
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int OCC_W  = PTR_W + 1;
  localparam int DSUM_W = CNT_W + 1;

  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [OCC_W-1:0] count_q, count_d;
  logic [SEQ_W-1:0] seq_q, seq_d;
  logic             overflow_q, overflow_d;
  logic [CNT_W-1:0] drop_q, drop_d;

  logic [XLEN-1:0]  pcMem   [DEPTH];
  logic [ILEN-1:0]  instMem [DEPTH];
  logic [SEQ_W-1:0] seqMem  [DEPTH];

  logic [NCOMMIT-1:0] laneValid;
  logic [OCC_W-1:0]   groupSize;
  logic [PTR_W-1:0]   laneOff  [NCOMMIT];
  logic [PTR_W-1:0]   laneSlot [NCOMMIT];
  logic [OCC_W-1:0]   freeSlots;
  logic               accept;
  logic               dropGroup;
  logic               pop;
  logic [DSUM_W-1:0]  dropSum;

  logic             entryWe   [DEPTH];
  logic [XLEN-1:0]  entryPc   [DEPTH];
  logic [ILEN-1:0]  entryInst [DEPTH];
  logic [SEQ_W-1:0] entrySeq  [DEPTH];

  // Count valid lanes and give each one its compacted offset within the group.
  always_comb begin
    laneValid = commit_valid & {NCOMMIT{enable}};
    groupSize = '0;
    for (int i = 0; i < NCOMMIT; i++) begin
      laneOff[i]  = groupSize[PTR_W-1:0];
      laneSlot[i] = wrPtr_q + groupSize[PTR_W-1:0];
      if (laneValid[i]) begin
        groupSize = groupSize + OCC_W'(1);
      end
    end
  end

  // Free space is taken from the registered occupancy only, so a same-cycle pop never makes room.
  always_comb begin
    freeSlots = OCC_W'(DEPTH) - count_q;
    accept    = (groupSize != '0) && (groupSize <= freeSlots);
    dropGroup = groupSize > freeSlots;
    pop       = read_valid && read_ready;
  end

  // Next-state for pointers, occupancy, sequence tag and drop status; clear wins over everything.
  always_comb begin
    wrPtr_d    = wrPtr_q;
    rdPtr_d    = rdPtr_q;
    count_d    = count_q;
    seq_d      = seq_q;
    overflow_d = overflow_q;
    drop_d     = drop_q;
    dropSum    = '0;
    if (clear) begin
      wrPtr_d    = '0;
      rdPtr_d    = '0;
      count_d    = '0;
      seq_d      = '0;
      overflow_d = 1'b0;
      drop_d     = '0;
    end else begin
      if (accept) begin
        wrPtr_d = wrPtr_q + groupSize[PTR_W-1:0];
      end
      if (pop) begin
        rdPtr_d = rdPtr_q + PTR_W'(1);
      end
      count_d = count_q + (accept ? groupSize : '0) - OCC_W'(pop);
      if (groupSize != '0) begin
        seq_d = seq_q + SEQ_W'(groupSize);
      end
      if (dropGroup) begin
        overflow_d = 1'b1;
        dropSum    = {1'b0, drop_q} + DSUM_W'(groupSize);
        drop_d     = dropSum[CNT_W] ? '1 : dropSum[CNT_W-1:0];
      end
    end
  end

  // Status and pointer registers, cleared asynchronously by reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      seq_q      <= '0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      count_q    <= count_d;
      seq_q      <= seq_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
    end
  end

  // Route each accepted lane to its storage slot as a per-entry write enable.
  always_comb begin
    for (int e = 0; e < DEPTH; e++) begin
      entryWe[e]   = 1'b0;
      entryPc[e]   = '0;
      entryInst[e] = '0;
      entrySeq[e]  = '0;
      for (int i = 0; i < NCOMMIT; i++) begin
        if (!clear && accept && laneValid[i] && (laneSlot[i] == PTR_W'(e))) begin
          entryWe[e]   = 1'b1;
          entryPc[e]   = commit_pc[i*XLEN +: XLEN];
          entryInst[e] = commit_inst[i*ILEN +: ILEN];
          entrySeq[e]  = seq_q + SEQ_W'(laneOff[i]);
        end
      end
    end
  end

  // Entry storage is data-only and deliberately left out of reset.
  for (genvar g = 0; g < DEPTH; g++) begin : gStore
    always_ff @(posedge clock) begin
      if (entryWe[g]) begin
        pcMem[g]   <= entryPc[g];
        instMem[g] <= entryInst[g];
        seqMem[g]  <= entrySeq[g];
      end
    end
  end

  assign read_valid = (count_q != '0);
  assign read_pc    = read_valid ? pcMem[rdPtr_q]   : '0;
  assign read_inst  = read_valid ? instMem[rdPtr_q] : '0;
  assign read_seq   = read_valid ? seqMem[rdPtr_q]  : '0;
  assign count      = count_q;
  assign overflow   = overflow_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_arch_step_trace_buffer.sv
// Testbench for arch_step_trace_buffer: directed scenarios followed by a
// randomized run, all checked against a queue-based reference model.
module tb_arch_step_trace_buffer;

  localparam int NC  = 2;
  localparam int DEP = 16;
  localparam int SW  = 4;
  localparam int CW  = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          enable;
  logic          clear;
  logic [1:0]    commitValid;
  logic [127:0]  commitPc;
  logic [63:0]   commitInst;
  logic          readReady;
  logic          readValid;
  logic [63:0]   readPc;
  logic [31:0]   readInst;
  logic [3:0]    readSeq;
  logic [4:0]    count;
  logic          overflow;
  logic [3:0]    dropCount;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
    int          seq;
  } entry_t;

  entry_t mq[$];
  int     mSeq;
  bit     mOvf;
  int     mDrop;

  int compared = 0;
  int mismatched = 0;

  arch_step_trace_buffer #(
    .NCOMMIT(NC), .XLEN(64), .ILEN(32), .DEPTH(DEP), .SEQ_W(SW), .CNT_W(CW)
  ) dut (
    .clock(clock),
    .reset(reset),
    .enable(enable),
    .clear(clear),
    .commit_valid(commitValid),
    .commit_pc(commitPc),
    .commit_inst(commitInst),
    .read_ready(readReady),
    .read_valid(readValid),
    .read_pc(readPc),
    .read_inst(readInst),
    .read_seq(readSeq),
    .count(count),
    .overflow(overflow),
    .drop_count(dropCount)
  );

  always #5 clock = ~clock;

  // Drive every DUT input for the coming clock edge.
  task automatic applyStimulus(input logic en, input logic clr, input logic [1:0] valid,
                               input logic [63:0] pc0, input logic [63:0] pc1,
                               input logic [31:0] inst0, input logic [31:0] inst1,
                               input logic rdy);
    enable      = en;
    clear       = clr;
    commitValid = valid;
    commitPc    = {pc1, pc0};
    commitInst  = {inst1, inst0};
    readReady   = rdy;
  endtask

  task automatic expectVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mq.delete();
    mSeq  = 0;
    mOvf  = 0;
    mDrop = 0;
  endtask

  // Advance the reference model by one clock edge using the current inputs.
  task automatic modelStep();
    int     free;
    int     n;
    int     k;
    bit     doPop;
    entry_t e;
    if (clear) begin
      modelReset();
    end else begin
      free  = DEP - mq.size();
      doPop = (mq.size() != 0) && readReady;
      n = 0;
      for (int i = 0; i < NC; i++) if (enable && commitValid[i]) n++;
      if (doPop) void'(mq.pop_front());
      if (n > 0) begin
        if (n <= free) begin
          k = 0;
          for (int i = 0; i < NC; i++) begin
            if (enable && commitValid[i]) begin
              e.pc   = commitPc[i*64 +: 64];
              e.inst = commitInst[i*32 +: 32];
              e.seq  = (mSeq + k) % 16;
              mq.push_back(e);
              k++;
            end
          end
        end else begin
          mOvf  = 1;
          mDrop = (mDrop + n > 15) ? 15 : mDrop + n;
        end
        mSeq = (mSeq + n) % 16;
      end
    end
  endtask

  task automatic checkOutput(input string tag);
    bit nonEmpty;
    nonEmpty = (mq.size() != 0);
    expectVal({tag, ".valid"}, 64'(readValid), 64'(nonEmpty));
    expectVal({tag, ".count"}, 64'(count), 64'(mq.size()));
    expectVal({tag, ".overflow"}, 64'(overflow), 64'(mOvf));
    expectVal({tag, ".drop"}, 64'(dropCount), 64'(mDrop));
    expectVal({tag, ".pc"}, readPc, nonEmpty ? mq[0].pc : 64'd0);
    expectVal({tag, ".inst"}, 64'(readInst), nonEmpty ? 64'(mq[0].inst) : 64'd0);
    expectVal({tag, ".seq"}, 64'(readSeq), nonEmpty ? 64'(mq[0].seq) : 64'd0);
  endtask

  task automatic cycle(input string tag);
    @(negedge clock);
    checkOutput(tag);
    modelStep();
    @(posedge clock);
    #1;
  endtask

  task automatic pushSingles(input int num, input logic [63:0] base, input logic rdy, input string tag);
    for (int k = 0; k < num; k++) begin
      applyStimulus(1'b1, 1'b0, 2'b01, base + 64'(4 * k), 64'd0, $urandom, 32'd0, rdy);
      cycle(tag);
    end
  endtask

  task automatic idleCycles(input int num, input logic rdy, input string tag);
    for (int k = 0; k < num; k++) begin
      applyStimulus(1'b1, 1'b0, 2'b00, 64'd0, 64'd0, 32'd0, 32'd0, rdy);
      cycle(tag);
    end
  endtask

  task automatic clearCycle();
    applyStimulus(1'b1, 1'b1, 2'b00, 64'd0, 64'd0, 32'd0, 32'd0, 1'b0);
    cycle("clr");
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 2'b00, 64'd0, 64'd0, 32'd0, 32'd0, 1'b0);
    modelReset();
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    checkOutput("reset");

    // Single lane capture and pop
    applyStimulus(1'b1, 1'b0, 2'b01, 64'h8000_0000, 64'd0, 32'h0000_0013, 32'd0, 1'b0);
    cycle("t1push");
    applyStimulus(1'b1, 1'b0, 2'b00, 64'd0, 64'd0, 32'd0, 32'd0, 1'b0);
    expectVal("t1pc", readPc, 64'h8000_0000);
    expectVal("t1inst", 64'(readInst), 64'h13);
    expectVal("t1seq", 64'(readSeq), 64'd0);
    expectVal("t1count", 64'(count), 64'd1);
    applyStimulus(1'b1, 1'b0, 2'b00, 64'd0, 64'd0, 32'd0, 32'd0, 1'b1);
    cycle("t1pop");
    expectVal("t1countAfter", 64'(count), 64'd0);
    expectVal("t1validAfter", 64'(readValid), 64'd0);

    // Dual-lane compaction
    clearCycle();
    applyStimulus(1'b1, 1'b0, 2'b10, 64'd0, 64'h100, 32'd0, 32'h11, 1'b0);
    cycle("t2a");
    applyStimulus(1'b1, 1'b0, 2'b11, 64'h104, 64'h108, 32'h22, 32'h33, 1'b0);
    cycle("t2b");
    for (int k = 0; k < 3; k++) begin
      expectVal("t2pc", readPc, 64'h100 + 64'(4 * k));
      expectVal("t2seq", 64'(readSeq), 64'(k));
      applyStimulus(1'b1, 1'b0, 2'b00, 64'd0, 64'd0, 32'd0, 32'd0, 1'b1);
      cycle("t2drain");
    end
    expectVal("t2empty", 64'(count), 64'd0);

    // Overflow of a 2-lane group, then full with simultaneous pop
    clearCycle();
    pushSingles(15, 64'h1000, 1'b0, "t3fill");
    applyStimulus(1'b1, 1'b0, 2'b11, 64'h1f00, 64'h1f04, 32'd1, 32'd2, 1'b0);
    cycle("t3drop");
    expectVal("t3count", 64'(count), 64'd15);
    expectVal("t3ovf", 64'(overflow), 64'd1);
    expectVal("t3drop", 64'(dropCount), 64'd2);
    pushSingles(1, 64'h2000, 1'b0, "t3last");
    expectVal("t3full", 64'(count), 64'd16);
    applyStimulus(1'b1, 1'b0, 2'b01, 64'h3000, 64'd0, 32'd5, 32'd0, 1'b1);
    cycle("t4fullPop");
    expectVal("t4drop", 64'(dropCount), 64'd3);
    expectVal("t4count", 64'(count), 64'd15);
    idleCycles(14, 1'b1, "t4drain");
    expectVal("t4seq17", 64'(readSeq), 64'd1);
    expectVal("t4pcLast", readPc, 64'h2000);
    idleCycles(1, 1'b1, "t4drainEnd");

    // Sequence wrap while streaming
    clearCycle();
    for (int k = 0; k < 18; k++) begin
      applyStimulus(1'b1, 1'b0, 2'b01, 64'h4000 + 64'(4 * k), 64'd0, $urandom, 32'd0, 1'b1);
      cycle("t5wrap");
      expectVal("t5seq", 64'(readSeq), 64'(k % 16));
    end
    idleCycles(1, 1'b1, "t5drain");

    // Asynchronous reset between clock edges
    clearCycle();
    pushSingles(17, 64'h6000, 1'b0, "t6fill");
    idleCycles(11, 1'b1, "t6drain");
    applyStimulus(1'b1, 1'b0, 2'b00, 64'd0, 64'd0, 32'd0, 32'd0, 1'b0);
    expectVal("t6preCount", 64'(count), 64'd5);
    expectVal("t6preOvf", 64'(overflow), 64'd1);
    #3 reset = 1'b1;
    #1;
    modelReset();
    expectVal("t6rstCount", 64'(count), 64'd0);
    expectVal("t6rstValid", 64'(readValid), 64'd0);
    expectVal("t6rstOvf", 64'(overflow), 64'd0);
    checkOutput("t6rst");
    #1 reset = 1'b0;
    @(posedge clock);
    #1;

    // Clear together with push and pop
    pushSingles(17, 64'h7000, 1'b0, "t7fill");
    applyStimulus(1'b1, 1'b1, 2'b11, 64'h7f00, 64'h7f04, 32'd9, 32'd8, 1'b1);
    cycle("t7clear");
    expectVal("t7count", 64'(count), 64'd0);
    expectVal("t7drop", 64'(dropCount), 64'd0);
    expectVal("t7ovf", 64'(overflow), 64'd0);
    pushSingles(1, 64'h5000, 1'b0, "t7push");
    expectVal("t7seq", 64'(readSeq), 64'd0);
    expectVal("t7pc", readPc, 64'h5000);

    // Randomized traffic
    for (int k = 0; k < 500; k++) begin
      applyStimulus(($urandom % 8) != 0, ($urandom % 64) == 0, 2'($urandom),
                    {$urandom, $urandom}, {$urandom, $urandom}, $urandom, $urandom,
                    ($urandom % 3) == 0);
      cycle("rand");
    end
    idleCycles(1, 1'b0, "final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
